instr_fetch_unit: RTL and testbench

Multicycle-CPU fetch stage that sits directly upstream of the controller: on a fetch request it reads one instruction word over a req/ack memory handshake with variable latency, then holds it in the instruction register. It decodes the fixed fields (op, funct, register and immediate fields) that the controller and datapath consume. Misaligned addresses, memory timeouts and branch flushes are handled here, so the controller only ever sees a complete, valid instruction.

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Memory read handshake between the fetch stage and instruction memory.
// The fetch unit drives req/addr; memory answers with ack/rdata.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: one req/ack read per fetch, instruction register,
// fixed-field decode, misalignment/timeout errors and branch flush handling.
module instr_fetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  instr_fetch_unit_if.master mem,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic              instr_valid,
  output logic              busy,
  output logic              fetch_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     wait_cnt;
  logic              discard;
  logic [ADDR_W-1:0] addr_q;

  // Request and busy are pure decodes of the state register, so an async
  // reset drops them immediately.
  assign mem.req  = (state == REQ);
  assign busy     = (state == REQ);
  assign mem.addr = addr_q;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign imm16 = instr[15:0];
  assign funct = instr[5:0];

  // Fetch FSM: accept requests, run the handshake, capture or drop data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
      discard     <= 1'b0;
      addr_q      <= '0;
    end else begin
      fetch_err <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (flush) instr_valid <= 1'b0;
          if (fetch_req) begin
            instr_valid <= 1'b0;
            if (pc[1:0] == 2'b00) begin
              addr_q   <= pc;
              discard  <= 1'b0;
              wait_cnt <= '0;
              state    <= REQ;
            end else begin
              fetch_err <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (flush) discard <= 1'b1;
          // An ack on the last allowed cycle beats the timeout.
          if (mem.ack) begin
            if (discard || flush) begin
              state <= IDLE;
            end else begin
              instr       <= mem.rdata;
              instr_valid <= 1'b1;
              state       <= DONE;
            end
          end else if (wait_cnt == LAST) begin
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed spec scenarios plus
// randomized fetches checked against a transaction-level reference model.
module tb_instr_fetch_unit;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        instr_valid, busy, fetch_err;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) mem ();

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
    .flush(flush), .mem(mem), .instr(instr), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] m_instr = '0;
  logic        m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_instr"}, instr, m_instr);
    check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, m_valid});
    check({tag, "_op"}, {26'd0, op}, {26'd0, m_instr[31:26]});
    check({tag, "_funct"}, {26'd0, funct}, {26'd0, m_instr[5:0]});
    check({tag, "_rs"}, {27'd0, rs}, {27'd0, m_instr[25:21]});
    check({tag, "_rt"}, {27'd0, rt}, {27'd0, m_instr[20:16]});
    check({tag, "_rd"}, {27'd0, rd}, {27'd0, m_instr[15:11]});
    check({tag, "_imm"}, {16'd0, imm16}, {16'd0, m_instr[15:0]});
  endtask

  // ack_n: REQ cycle carrying the ack (0 = never, i.e. timeout).
  // flush_n: REQ cycle carrying a flush (0 = none).
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d,
                          input int ack_n, input int flush_n,
                          input logic flush_with_req);
    fetch_req = 1'b1;
    pc = a;
    flush = flush_with_req;
    tick();
    fetch_req = 1'b0;
    flush = 1'b0;
    pc = $urandom;
    m_valid = 1'b0;
    if (a[1:0] != 2'b00) begin
      check("mis_err", {31'd0, fetch_err}, 32'd1);
      check("mis_req", {31'd0, mem.req}, 32'd0);
      check_regs("mis");
      tick();
      check("mis_err_clr", {31'd0, fetch_err}, 32'd0);
      check("mis_req2", {31'd0, mem.req}, 32'd0);
      return;
    end
    for (int k = 1; k <= MAX_WAIT; k++) begin
      check("req", {31'd0, mem.req}, 32'd1);
      check("busy", {31'd0, busy}, 32'd1);
      check("addr", mem.addr, a);
      check("err_low", {31'd0, fetch_err}, 32'd0);
      check("valid_low", {31'd0, instr_valid}, 32'd0);
      mem.ack = (k == ack_n);
      mem.rdata = (k == ack_n) ? d : $urandom;
      flush = (k == flush_n);
      tick();
      mem.ack = 1'b0;
      flush = 1'b0;
      if (k == ack_n) break;
    end
    if (ack_n != 0 && flush_n == 0) begin
      m_instr = d;
      m_valid = 1'b1;
    end
    check("req_end", {31'd0, mem.req}, 32'd0);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("err_end", {31'd0, fetch_err}, {31'd0, ack_n == 0});
    check_regs("end");
    if (ack_n == 0) begin
      tick();
      check("err_pulse", {31'd0, fetch_err}, 32'd0);
    end
  endtask

  initial begin
    mem.ack = 1'b0;
    mem.rdata = '0;
    tick();
    tick();
    check("rst_req", {31'd0, mem.req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", mem.addr, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check_regs("rst");
    reset = 1'b0;
    tick();

    do_fetch(32'h40, 32'h012A4020, 1, 0, 1'b0);
    check("zw_op", {26'd0, op}, 32'h0);
    check("zw_funct", {26'd0, funct}, 32'h20);
    check("zw_rs", {27'd0, rs}, 32'd9);
    check("zw_rt", {27'd0, rt}, 32'd10);
    check("zw_rd", {27'd0, rd}, 32'd8);

    do_fetch(32'h44, 32'h8C880004, 5, 0, 1'b0);
    check("ws_op", {26'd0, op}, 32'h23);
    check("ws_imm", {16'd0, imm16}, 32'h4);

    do_fetch(32'h48, 32'hDEADBEEF, 0, 0, 1'b0);
    check("to_instr", instr, 32'h8C880004);
    do_fetch(32'h4C, 32'h11223344, MAX_WAIT, 0, 1'b0);

    do_fetch(32'h42, 32'h0, 0, 0, 1'b0);
    tick();
    check("mis_idle_req", {31'd0, mem.req}, 32'd0);

    do_fetch(32'h50, 32'h55667788, 4, 1, 1'b0);
    check("fl_valid", {31'd0, instr_valid}, 32'd0);

    do_fetch(32'h54, 32'hA5A5A5A5, 2, 0, 1'b0);
    do_fetch(32'h58, 32'h0BADF00D, 1, 0, 1'b1);

    flush = 1'b1;
    mem.ack = 1'b1;
    mem.rdata = 32'hFFFF0000;
    tick();
    flush = 1'b0;
    m_valid = 1'b0;
    check_regs("idle_flush");
    tick();
    mem.ack = 1'b0;
    check_regs("idle_ack");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      int an, fn, gap;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      an = $urandom_range(0, MAX_WAIT);
      fn = (an > 1 && $urandom_range(0, 3) == 0) ?
           $urandom_range(1, an - 1) : 0;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      do_fetch(a, $urandom, an, fn, 1'($urandom_range(0, 1)));
    end

    fetch_req = 1'b1;
    pc = 32'h100;
    tick();
    fetch_req = 1'b0;
    tick();
    check("pre_rst_req", {31'd0, mem.req}, 32'd1);
    reset = 1'b1;
    #1;
    m_instr = '0;
    m_valid = 1'b0;
    check("arst_req", {31'd0, mem.req}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_addr", mem.addr, 32'd0);
    check("arst_err", {31'd0, fetch_err}, 32'd0);
    check_regs("arst");
    @(negedge clk);
    reset = 1'b0;
    tick();
    mem.ack = 1'b1;
    mem.rdata = 32'h12345678;
    tick();
    mem.ack = 1'b0;
    check("late_req", {31'd0, mem.req}, 32'd0);
    check_regs("late_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
